// File: rtl/maxpool_l1.sv
// maxpool_l1: 2x2 stride-2 max-pooling of both L0 kernels into the L1 memories.
// Define MAXPOOL_CEIL_EN to round each pooled value up to an integer.
module maxpool_l1 #(
    parameter int DW    = 20,
    parameter int AW    = 12,
    parameter int IMG_W = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    output logic          busy,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);

    localparam int LW = $clog2(IMG_W);
    localparam int HW = LW - 1;
    localparam int PW = 2 * HW;
    localparam int FB = 16;
    localparam logic [DW-FB-1:0] INT_ONE = {{(DW-FB-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_LAST, S_WR, S_NEXT, S_DONE
    } state_t;

    state_t                r_state, w_state;
    logic [PW-1:0]         r_p, w_p;
    logic                  r_kernel, w_kernel;
    logic signed [DW-1:0]  r_max, w_max;
    logic                  r_busy, w_busy;
    logic                  r_crd, w_crd;
    logic [AW-1:0]         r_caddr_rd, w_caddr_rd;
    logic                  r_cwr, w_cwr;
    logic [AW-1:0]         r_caddr_wr, w_caddr_wr;
    logic [DW-1:0]         r_cdata_wr, w_cdata_wr;
    logic [2:0]            r_csel, w_csel;
    logic signed [DW-1:0]  w_max_upd;
    logic [DW-1:0]         w_pooled;

    // Window element (dy,dx) of pooled index p sits at {py,dy,px,dx}.
    function automatic logic [AW-1:0] rd_addr(input logic [PW-1:0] p,
                                              input logic dy,
                                              input logic dx);
        return AW'({p[PW-1:HW], dy, p[HW-1:0], dx});
    endfunction

    function automatic logic [2:0] rd_sel(input logic k);
        return k ? 3'b010 : 3'b001;
    endfunction

    assign w_max_upd = ($signed(cdata_rd) > r_max) ? $signed(cdata_rd) : r_max;

`ifdef MAXPOOL_CEIL_EN
    assign w_pooled = (w_max_upd[FB-1:0] != '0)
                    ? {w_max_upd[DW-1:FB] + INT_ONE, {FB{1'b0}}}
                    : w_max_upd;
`else
    assign w_pooled = w_max_upd;
`endif

    always_comb begin
        w_state    = r_state;
        w_p        = r_p;
        w_kernel   = r_kernel;
        w_max      = r_max;
        w_busy     = r_busy;
        w_crd      = r_crd;
        w_caddr_rd = r_caddr_rd;
        w_cwr      = r_cwr;
        w_caddr_wr = r_caddr_wr;
        w_cdata_wr = r_cdata_wr;
        w_csel     = r_csel;
        unique case (r_state)
            S_IDLE: begin
                if (ready) begin
                    w_state    = S_RD0;
                    w_busy     = 1'b1;
                    w_crd      = 1'b1;
                    w_caddr_rd = rd_addr(r_p, 1'b0, 1'b0);
                    w_csel     = rd_sel(r_kernel);
                end
            end
            S_RD0: begin
                w_state    = S_RD1;
                w_caddr_rd = rd_addr(r_p, 1'b0, 1'b1);
            end
            S_RD1: begin
                w_state    = S_RD2;
                w_caddr_rd = rd_addr(r_p, 1'b1, 1'b0);
                w_max      = $signed(cdata_rd);
            end
            S_RD2: begin
                w_state    = S_RD3;
                w_caddr_rd = rd_addr(r_p, 1'b1, 1'b1);
                w_max      = w_max_upd;
            end
            S_RD3: begin
                w_state = S_LAST;
                w_crd   = 1'b0;
                w_max   = w_max_upd;
            end
            S_LAST: begin
                w_state    = S_WR;
                w_max      = w_max_upd;
                w_cwr      = 1'b1;
                w_caddr_wr = AW'(r_p);
                w_cdata_wr = w_pooled;
                w_csel     = r_kernel ? 3'b100 : 3'b011;
            end
            S_WR: begin
                w_state = S_NEXT;
                w_cwr   = 1'b0;
            end
            S_NEXT: begin
                w_p = r_p + PW'(1);
                if ((&r_p) && r_kernel) begin
                    w_state = S_DONE;
                end else begin
                    if (&r_p) w_kernel = 1'b1;
                    w_state    = S_RD0;
                    w_crd      = 1'b1;
                    w_caddr_rd = rd_addr(w_p, 1'b0, 1'b0);
                    w_csel     = rd_sel(w_kernel);
                end
            end
            S_DONE: begin
                w_state  = S_IDLE;
                w_busy   = 1'b0;
                w_csel   = 3'b000;
                w_kernel = 1'b0;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_p        <= '0;
            r_kernel   <= 1'b0;
            r_max      <= '0;
            r_busy     <= 1'b0;
            r_crd      <= 1'b0;
            r_caddr_rd <= '0;
            r_cwr      <= 1'b0;
            r_caddr_wr <= '0;
            r_cdata_wr <= '0;
            r_csel     <= 3'b000;
        end else begin
            r_state    <= w_state;
            r_p        <= w_p;
            r_kernel   <= w_kernel;
            r_max      <= w_max;
            r_busy     <= w_busy;
            r_crd      <= w_crd;
            r_caddr_rd <= w_caddr_rd;
            r_cwr      <= w_cwr;
            r_caddr_wr <= w_caddr_wr;
            r_cdata_wr <= w_cdata_wr;
            r_csel     <= w_csel;
        end
    end

    assign busy     = r_busy;
    assign crd      = r_crd;
    assign caddr_rd = r_caddr_rd;
    assign cwr      = r_cwr;
    assign caddr_wr = r_caddr_wr;
    assign cdata_wr = r_cdata_wr;
    assign csel     = r_csel;

endmodule

// File: tb/tb_maxpool_l1.sv
// Directed bench for maxpool_l1 with L0 read memory model and L1 write capture.
module tb_maxpool_l1;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        busy;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic [2:0]  csel;

    int checks = 0;
    int errors = 0;

    logic [19:0] mem0 [4096];
    logic [19:0] mem1 [4096];
    logic [19:0] l1a  [1024];
    logic [19:0] l1b  [1024];
    logic [11:0] rd_a [8192];
    logic [2:0]  rd_s [8192];

    maxpool_l1 #(.DW(20), .AW(12), .IMG_W(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .ready    (ready),
        .busy     (busy),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .cdata_rd (cdata_rd),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr),
        .csel     (csel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (crd) cdata_rd <= (csel == 3'b010) ? mem1[caddr_rd] : mem0[caddr_rd];
    end

    function automatic logic [19:0] exp_out(input logic [19:0] v);
`ifdef MAXPOOL_CEIL_EN
        return (v[15:0] != 16'h0) ? {v[19:16] + 4'd1, 16'h0} : v;
`else
        return v;
`endif
    endfunction

    task automatic start_run();
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;
    endtask

    task automatic abort_run();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy, crd, cwr, csel} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%b crd=%b cwr=%b csel=%b required all 0",
                     busy, crd, cwr, csel);
        end
        checks++;
        if ({caddr_rd, caddr_wr} !== 24'h0) begin
            errors++;
            $display("FAIL reset_addr: got rd=%h wr=%h required 000 000", caddr_rd, caddr_wr);
        end
        checks++;
        if (cdata_wr !== 20'h0) begin
            errors++;
            $display("FAIL reset_data: got %h required 00000", cdata_wr);
        end
        reset = 1'b0;
    endtask

    task automatic test_const_window();
        logic [47:0] seq;
        logic        crd_ok;
        bit          seen;
        start_run();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise: got %b required 1", busy);
        end
        crd_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            seq = {seq[35:0], caddr_rd};
            if (crd !== 1'b1 || csel !== 3'b001) crd_ok = 1'b0;
            if (i < 3) @(negedge clk);
        end
        checks++;
        if (seq !== 48'h000_001_040_041) begin
            errors++;
            $display("FAIL rd_seq: got %h required 000001040041", seq);
        end
        checks++;
        if (crd_ok !== 1'b1) begin
            errors++;
            $display("FAIL rd_strobe: got crd/csel wrong required crd=1 csel=001");
        end
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (cwr) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wr0_timeout: got no cwr required pulse within 20 cycles");
        end else begin
            checks++;
            if ({caddr_wr, csel} !== {12'h000, 3'b011}) begin
                errors++;
                $display("FAIL wr0_addr: got %h csel=%b required 000 csel=011",
                         caddr_wr, csel);
            end
            checks++;
            if (cdata_wr !== exp_out(20'h03000)) begin
                errors++;
                $display("FAIL wr0_data: got %h required %h", cdata_wr, exp_out(20'h03000));
            end
        end
        abort_run();
    endtask

    task automatic test_full_run();
        int  busy_cyc = 0;
        int  nrd = 0;
        int  nwr3 = 0;
        int  nwr4 = 0;
        int  werr = 0;
        bit  done = 0;
        start_run();
        for (int c = 0; c < 20000 && !done; c++) begin
            if (busy) busy_cyc++;
            if (crd && nrd < 8192) begin
                rd_a[nrd] = caddr_rd;
                rd_s[nrd] = csel;
                nrd++;
            end
            if (cwr) begin
                if (csel == 3'b011) begin
                    if (caddr_wr != 12'(nwr3)) werr++;
                    l1a[caddr_wr[9:0]] = cdata_wr;
                    nwr3++;
                end else if (csel == 3'b100) begin
                    if (caddr_wr != 12'(nwr4) || nwr3 != 1024) werr++;
                    l1b[caddr_wr[9:0]] = cdata_wr;
                    nwr4++;
                end else begin
                    werr++;
                end
            end
            if (!busy) done = 1;
            else @(negedge clk);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL run_timeout: got busy still 1 required drop within 20000 cycles");
        end
        checks++;
        if (busy_cyc != 2048 * 7 + 1) begin
            errors++;
            $display("FAIL busy_len: got %0d required %0d", busy_cyc, 2048 * 7 + 1);
        end
        checks++;
        if (nwr3 != 1024 || nwr4 != 1024 || werr != 0) begin
            errors++;
            $display("FAIL wr_count: got k0=%0d k1=%0d bad=%0d required 1024 1024 0",
                     nwr3, nwr4, werr);
        end
        checks++;
        if (nrd != 8192) begin
            errors++;
            $display("FAIL rd_count: got %0d required 8192", nrd);
        end
        checks++;
        if ({rd_a[4092], rd_a[4093], rd_a[4094], rd_a[4095]} !== 48'hFBE_FBF_FFE_FFF
            || rd_s[4095] !== 3'b001) begin
            errors++;
            $display("FAIL last_rd: got %h %h %h %h csel=%b required FBE FBF FFE FFF csel=001",
                     rd_a[4092], rd_a[4093], rd_a[4094], rd_a[4095], rd_s[4095]);
        end
        checks++;
        if ({rd_a[4096], rd_s[4096]} !== {12'h000, 3'b010}) begin
            errors++;
            $display("FAIL k_switch: got %h csel=%b required 000 csel=010",
                     rd_a[4096], rd_s[4096]);
        end
        checks++;
        if (l1a[1023] !== exp_out(20'h12345)) begin
            errors++;
            $display("FAIL last_wr: got %h required %h", l1a[1023], exp_out(20'h12345));
        end
        checks++;
        if (l1a[5] !== exp_out(20'h0004B)) begin
            errors++;
            $display("FAIL k0_p5: got %h required %h", l1a[5], exp_out(20'h0004B));
        end
        checks++;
        if (l1b[0] !== 20'h00000) begin
            errors++;
            $display("FAIL signed_cmp: got %h required 00000", l1b[0]);
        end
        checks++;
        if (l1b[1] !== exp_out(20'h10043)) begin
            errors++;
            $display("FAIL k1_p1: got %h required %h", l1b[1], exp_out(20'h10043));
        end
        checks++;
        if (l1b[2] !== 20'h30000) begin
            errors++;
            $display("FAIL int_val: got %h required 30000", l1b[2]);
        end
        @(negedge clk);
        checks++;
        if ({busy, csel} !== 4'b0) begin
            errors++;
            $display("FAIL post_run: got busy=%b csel=%b required 0 000", busy, csel);
        end
    endtask

    task automatic test_midrun_reset();
        bit seen = 0;
        start_run();
        for (int c = 0; c < 10000 && !seen; c++) begin
            @(negedge clk);
            if (cwr && caddr_wr == 12'd500) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL p500_timeout: got no write at 500 required one within 10000 cycles");
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({busy, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr} !== 50'h0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b crd=%b cwr=%b csel=%b rd=%h wr=%h d=%h required all 0",
                     busy, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr);
        end
        start_run();
        checks++;
        if ({busy, crd, csel, caddr_rd} !== {1'b1, 1'b1, 3'b001, 12'h000}) begin
            errors++;
            $display("FAIL restart_rd: got busy=%b crd=%b csel=%b rd=%h required 1 1 001 000",
                     busy, crd, csel, caddr_rd);
        end
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (cwr) seen = 1;
        end
        checks++;
        if (!seen || {caddr_wr, csel} !== {12'h000, 3'b011} || cdata_wr !== exp_out(20'h03000)) begin
            errors++;
            $display("FAIL restart_wr: got seen=%b wr=%h csel=%b d=%h required 1 000 011 %h",
                     seen, caddr_wr, csel, cdata_wr, exp_out(20'h03000));
        end
        abort_run();
    endtask

    initial begin
        reset    = 1'b1;
        ready    = 1'b0;
        cdata_rd = '0;
        for (int a = 0; a < 4096; a++) begin
            mem0[a] = 20'(a);
            mem1[a] = 20'h10000 | 20'(a);
        end
        mem0[12'h000] = 20'h01000;
        mem0[12'h001] = 20'h03000;
        mem0[12'h040] = 20'h02000;
        mem0[12'h041] = 20'h00800;
        mem0[12'hFBE] = 20'h00010;
        mem0[12'hFBF] = 20'h12345;
        mem0[12'hFFE] = 20'h10000;
        mem0[12'hFFF] = 20'h02345;
        mem1[12'h000] = 20'hFFFFF;
        mem1[12'h001] = 20'h00000;
        mem1[12'h040] = 20'hF0000;
        mem1[12'h041] = 20'hFFFF0;
        mem1[12'h004] = 20'h30000;
        mem1[12'h005] = 20'h00000;
        mem1[12'h044] = 20'h00000;
        mem1[12'h045] = 20'h00000;

        test_reset();
        test_const_window();
        test_full_run();
        test_midrun_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/maxpool_l1.md
Name: maxpool_l1

Overview:
- Layer-1 stage of the CNN accelerator.
- Reads the layer-0 convolution results that the CONV stage wrote to the L0 memories, applies 2x2 stride-2 max-pooling, and writes 32x32 results to the L1 memories.
- Processes kernel 0 (L0 csel 001 -> L1 csel 011), then kernel 1 (L0 csel 010 -> L1 csel 100).
- Acts as the read-side counterpart of the CONV write port, sharing the same crd/caddr_rd/cdata_rd and cwr/caddr_wr/cdata_wr/csel bus.

Parameters:
- DW, 20, data width; signed 4.16 fixed point.
- AW, 12, memory address width.
- IMG_W, 64, L0 image side (power of two); L1 side is IMG_W/2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ready  in  1  start request; sampled only in IDLE
- busy  out  1  high from the cycle after ready is accepted until DONE
- crd  out  1  L0 read strobe
- caddr_rd  out  AW  L0 read address {row[5:0], col[5:0]}
- cdata_rd  in  DW  L0 read data; valid the cycle after crd/caddr_rd
- cwr  out  1  L1 write strobe, one-cycle pulse
- caddr_wr  out  AW  L1 write address {2'b00, py[4:0], px[4:0]}
- cdata_wr  out  DW  pooled value
- csel  out  3  memory select: 001/010 during L0 reads, 011/100 during L1 writes

Behaviour:
- Reset (synchronous, active-high, takes effect at any point mid-operation): state=IDLE; busy, crd, cwr = 0; caddr_rd, caddr_wr, cdata_wr = 0; csel = 000; kernel bit = 0; pooled counter p = 0; max register = 0.
- All outputs are registered.
- State machine: IDLE -> RD0 -> RD1 -> RD2 -> RD3 -> LAST -> WR -> NEXT -> (RD0 | DONE); DONE -> IDLE.
- IDLE: on ready=1, go to RD0 next cycle and set busy=1 on that edge. Otherwise remain in IDLE.
- Window for pooled index p={py,px}: reads are issued in the order (2py,2px), (2py,2px+1), (2py+1,2px), (2py+1,2px+1).
- RD0..RD3: each state drives crd=1, the corresponding caddr_rd, and csel = kernel ? 010 : 001.
- Data capture is one cycle behind the read issue:
  - RD1 loads max <= cdata_rd (first element).
  - RD2, RD3 and LAST update max <= (cdata_rd > max, signed) ? cdata_rd : max.
- LAST: crd=0.
- WR: cwr=1, caddr_wr={2'b00,p}, cdata_wr=max (see the optional feature), csel = kernel ? 100 : 011.
- NEXT: cwr=0, p <= p+1 (wraps 1023 -> 0).
  - If p==1023 and kernel==0: kernel <= 1, go to RD0.
  - If p==1023 and kernel==1: go to DONE.
  - Otherwise: go to RD0.
- Throughput: 7 cycles per pooled output; 2 x 1024 outputs per run.
- DONE: busy <= 0, csel <= 000, kernel <= 0, go to IDLE.
- ready is ignored while busy=1. A new run may start from IDLE on the cycle after DONE.
- Equal values: comparison is strict (>), so the earlier element is kept. The result is bit-identical either way.
- Negative inputs: compare as signed, even though the ReLU in L0 normally guarantees values >= 0.

Optional Feature:
- Macro: MAXPOOL_CEIL_EN.
- Defined: cdata_wr = max rounded up to an integer. If max[15:0] != 0, output {max[19:16]+1, 16'h0}; otherwise output max. The integer part wraps silently on overflow.
- Undefined: cdata_wr = max unmodified.

Test Plan:
- Constant window: L0 k0 window at p=0 holds {0x01000, 0x03000, 0x02000, 0x00800} -> at p=0, cwr=1 with caddr_wr=0x000, cdata_wr=0x03000, csel=011. Issued caddr_rd sequence is 0x000, 0x001, 0x040, 0x041.
- Last window / kernel switch: at p=1023 the reads are 0xFBE, 0xFBF, 0xFFE, 0xFFF. Max 0x12345 is written at caddr_wr=0x3FF. The next read cycle has csel=010 and caddr_rd=0x000.
- Ceil enabled: max=0x12345 -> cdata_wr=0x20000; max=0x30000 -> 0x30000. Ceil disabled: 0x12345 is passed through.
- Signed compare: window {0xFFFFF, 0x00000, 0xF0000, 0xFFFF0} -> 0x00000.
- Full run: ready pulsed for 1 cycle -> busy rises the next cycle and stays high for 2048x7 cycles plus a few. Exactly 2048 cwr pulses occur, 1024 each with csel 011 and 100. busy=0 and csel=000 afterwards.
- Mid-run reset: reset asserted for 1 cycle at p=500 -> all outputs are 0 on the next edge and state is IDLE. A fresh ready restarts at p=0 with kernel 0.
